fft_req_scheduler: RTL and testbench

// - Shares one 4-point FFT core among NUM_REQ sample sources; round-robin arbitration.
// - Sequences each job through the core: launch, start-ack, completion, result capture.
// - Returns results on a valid/ready channel tagged with the requester id.
// - Sits between the sample front-ends and the FFT core; the core itself is not modified.

---
 rtl/fft_sched_pkg.sv | 36 +++
 rtl/fft_req_scheduler_arbiter.sv | 33 +++
 rtl/fft_req_scheduler.sv | 160 ++++++++++++++++
 tb/tb_fft_req_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the FFT request scheduler.
package fft_sched_pkg;

  localparam int PT_W    = 10;
  localparam int FREQ_W  = 16;
  localparam int N_PTS   = 4;
  localparam int FRAME_W = PT_W * N_PTS;
  localparam int RES_W   = FREQ_W * N_PTS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    ARM     = 3'd2,
    WAIT    = 3'd3,
    SETTLE  = 3'd4,
    CAPTURE = 3'd5,
    RESP    = 3'd6
  } state_t;

  // One requester frame as it sits on req_pts: pt0 in the low bits.
  typedef struct packed {
    logic signed [PT_W-1:0] pt3;
    logic signed [PT_W-1:0] pt2;
    logic signed [PT_W-1:0] pt1;
    logic signed [PT_W-1:0] pt0;
  } frame_t;

  // One core result as presented on res_freq: freq0 in the low bits.
  typedef struct packed {
    logic signed [FREQ_W-1:0] freq3;
    logic signed [FREQ_W-1:0] freq2;
    logic signed [FREQ_W-1:0] freq1;
    logic signed [FREQ_W-1:0] freq0;
  } result_t;

endpackage

// File: rtl/fft_req_scheduler_arbiter.sv
// Round-robin arbiter: picks the first set request at or after ptr,
// wrapping from N-1 back to 0. Purely combinational.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  // Scan requesters in rotated order starting from ptr; first hit wins.
  always_comb begin
    int   k;
    logic hit;
    k         = 0;
    hit       = 1'b0;
    grant     = {N{1'b0}};
    grant_idx = {IW{1'b0}};
    grant_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      k         = int'(ptr) + i;
      k         = (k >= N) ? (k - N) : k;
      hit       = req[k] & ~grant_any;
      grant[k]  = hit;
      grant_idx = hit ? IW'(k) : grant_idx;
      grant_any = grant_any | hit;
    end
  end

endmodule

// File: rtl/fft_req_scheduler.sv
// Shares one 4-point FFT core between NUM_REQ sample sources. Jobs are
// granted round-robin, run one at a time through the core, and the result
// is returned on a valid/ready channel tagged with the requester id.
module fft_req_scheduler
  import fft_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*FRAME_W-1:0]   req_pts,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         core_new_t,
  output logic [PT_W-1:0]              core_pt0,
  output logic [PT_W-1:0]              core_pt1,
  output logic [PT_W-1:0]              core_pt2,
  output logic [PT_W-1:0]              core_pt3,
  input  logic                         core_done,
  input  logic [FREQ_W-1:0]            core_freq0,
  input  logic [FREQ_W-1:0]            core_freq1,
  input  logic [FREQ_W-1:0]            core_freq2,
  input  logic [FREQ_W-1:0]            core_freq3,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [$clog2(NUM_REQ)-1:0]   res_id,
  output logic [RES_W-1:0]             res_freq,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  // The counter value on which one more ARM/WAIT cycle reaches TIMEOUT_CYC.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t              state_r;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [CNT_W-1:0]    cnt_r;

  logic [NUM_REQ-1:0]  arb_gnt_s;
  logic [ID_W-1:0]     arb_idx_s;
  logic                arb_any_s;
  frame_t              win_frame_s;
  result_t             core_res_s;

  // Successor of a requester id, wrapping at NUM_REQ-1.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) begin
      return {ID_W{1'b0}};
    end else begin
      return id + ID_W'(1);
    end
  endfunction

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req       (req),
    .ptr       (rr_ptr_r),
    .grant     (arb_gnt_s),
    .grant_idx (arb_idx_s),
    .grant_any (arb_any_s)
  );

  assign win_frame_s = frame_t'(req_pts[int'(arb_idx_s)*FRAME_W +: FRAME_W]);
  assign core_res_s  = '{freq3: core_freq3, freq2: core_freq2,
                         freq1: core_freq1, freq0: core_freq0};

  // Job sequencer: arbitration, core handshake, timeout and result hand-off.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {ID_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      gnt         <= {NUM_REQ{1'b0}};
      core_new_t  <= 1'b0;
      core_pt0    <= {PT_W{1'b0}};
      core_pt1    <= {PT_W{1'b0}};
      core_pt2    <= {PT_W{1'b0}};
      core_pt3    <= {PT_W{1'b0}};
      res_valid   <= 1'b0;
      res_id      <= {ID_W{1'b0}};
      res_freq    <= {RES_W{1'b0}};
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Pulse outputs fall back to 0 unless a branch below raises them.
      gnt         <= {NUM_REQ{1'b0}};
      core_new_t  <= 1'b0;
      timeout_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (arb_any_s) begin
            gnt        <= arb_gnt_s;
            core_pt0   <= win_frame_s.pt0;
            core_pt1   <= win_frame_s.pt1;
            core_pt2   <= win_frame_s.pt2;
            core_pt3   <= win_frame_s.pt3;
            res_id     <= arb_idx_s;
            // Raised here so the start strobe is visible while in LAUNCH.
            core_new_t <= 1'b1;
            cnt_r      <= {CNT_W{1'b0}};
            busy       <= 1'b1;
            state_r    <= LAUNCH;
          end else begin
            busy <= 1'b0;
          end
        end
        LAUNCH: begin
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= ARM;
        end
        ARM, WAIT: begin
          if (cnt_r == CNT_LAST) begin
            // Core never acknowledged or never finished: drop the job.
            timeout_err <= 1'b1;
            rr_ptr_r    <= next_id(res_id);
            busy        <= 1'b0;
            state_r     <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            if ((state_r == ARM) && !core_done) begin
              state_r <= WAIT;
            end else if ((state_r == WAIT) && core_done) begin
              state_r <= SETTLE;
            end else begin
              state_r <= state_r;
            end
          end
        end
        SETTLE: begin
          state_r <= CAPTURE;
        end
        CAPTURE: begin
          res_freq  <= core_res_s;
          res_valid <= 1'b1;
          state_r   <= RESP;
        end
        RESP: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            rr_ptr_r  <= next_id(res_id);
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_req_scheduler.sv
// Scoreboard bench for fft_req_scheduler: stimulus pushes expected grants,
// core frames and results; a monitor pops and compares as the DUT emits them.
module tb_fft_req_scheduler;

  logic         clk_in = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [159:0] req_pts;
  logic [3:0]   gnt;
  logic         core_new_t;
  logic [9:0]   core_pt0, core_pt1, core_pt2, core_pt3;
  logic         core_done;
  logic [15:0]  core_freq0, core_freq1, core_freq2, core_freq3;
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_id;
  logic [63:0]  res_freq;
  logic         busy;
  logic         timeout_err;

  fft_req_scheduler #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .req         (req),
    .req_pts     (req_pts),
    .gnt         (gnt),
    .core_new_t  (core_new_t),
    .core_pt0    (core_pt0),
    .core_pt1    (core_pt1),
    .core_pt2    (core_pt2),
    .core_pt3    (core_pt3),
    .core_done   (core_done),
    .core_freq0  (core_freq0),
    .core_freq1  (core_freq1),
    .core_freq2  (core_freq2),
    .core_freq3  (core_freq3),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_freq    (res_freq),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  int n_gnt_seen = 0;
  int n_res_seen = 0;
  int n_to_seen  = 0;

  logic [3:0]  exp_gnt_q[$];
  logic [39:0] exp_frame_q[$];
  logic [65:0] exp_res_q[$];
  logic [63:0] core_resp_q[$];

  logic [39:0] frm [4];

  bit          core_stuck;
  int          core_lat;
  int          ccnt;
  logic [63:0] cur_resp;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic smp();
    @(negedge clk_in);
    #1;
  endtask

  task automatic drv();
    @(posedge clk_in);
    #1;
  endtask

  // Queue everything one job is expected to produce.
  task automatic push_job(input int id, input logic [63:0] resp, input bit use_core, input bit with_res);
    exp_gnt_q.push_back(4'b0001 << id);
    exp_frame_q.push_back(frm[id]);
    if (use_core) core_resp_q.push_back(resp);
    if (with_res) exp_res_q.push_back({2'(id), resp});
  endtask

  task automatic wait_gnts(input int target);
    int k = 0;
    while (n_gnt_seen < target && k < 300) begin smp(); k++; end
    check("gnt_wait", 80'(n_gnt_seen), 80'(target));
  endtask

  task automatic wait_res(input int target);
    int k = 0;
    while (n_res_seen < target && k < 300) begin smp(); k++; end
    check("res_wait", 80'(n_res_seen), 80'(target));
  endtask

  // FFT core model: after a start strobe, drop done for core_lat cycles,
  // then raise it with the queued result.
  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      core_done <= 1'b1;
      ccnt      <= 0;
      {core_freq3, core_freq2, core_freq1, core_freq0} <= 64'h0;
    end else if (core_new_t && !core_stuck) begin
      if (core_resp_q.size() > 0) cur_resp = core_resp_q.pop_front();
      else cur_resp = 64'h0;
      core_done <= 1'b0;
      ccnt      <= core_lat;
    end else if (ccnt > 0) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1) begin
        core_done <= 1'b1;
        {core_freq3, core_freq2, core_freq1, core_freq0} <= cur_resp;
      end
    end
  end

  // Monitor: compare every grant, core launch and accepted result.
  always @(negedge clk_in) begin
    if (reset === 1'b0) begin
      if (gnt != 4'b0) begin
        n_gnt_seen++;
        if (exp_gnt_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_gnt: got %h expected none", gnt);
        end else check("gnt", 80'(gnt), 80'(exp_gnt_q.pop_front()));
      end
      if (core_new_t) begin
        if (exp_frame_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_launch: got %h expected none", {core_pt3, core_pt2, core_pt1, core_pt0});
        end else check("core_pts", 80'({core_pt3, core_pt2, core_pt1, core_pt0}), 80'(exp_frame_q.pop_front()));
      end
      if (res_valid && res_ready) begin
        n_res_seen++;
        if (exp_res_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got %h expected none", {res_id, res_freq});
        end else check("result", 80'({res_id, res_freq}), 80'(exp_res_q.pop_front()));
      end
      if (timeout_err) n_to_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit saw_v;
    logic [15:0] jj;
    frm[0] = {10'd0, 10'd0, 10'd0, 10'd4};
    frm[1] = {10'd1, 10'd2, 10'd3, 10'd5};
    frm[2] = {10'h3FF, 10'h200, 10'd0, 10'd7};
    frm[3] = {10'd100, 10'd200, 10'd300, 10'd400};
    req_pts    = {frm[3], frm[2], frm[1], frm[0]};
    req        = 4'b0;
    res_ready  = 1'b0;
    core_stuck = 1'b0;
    core_lat   = 1;
    reset      = 1'b0;
    #1 reset   = 1'b1;
    repeat (3) smp();
    check("rst_gnt", 80'(gnt), 80'(4'b0));
    check("rst_ctl", 80'({core_new_t, res_valid, busy, timeout_err}), 80'(4'b0));
    check("rst_pts", 80'({core_pt3, core_pt2, core_pt1, core_pt0}), 80'(40'h0));
    check("rst_res", 80'({res_id, res_freq}), 80'(66'h0));
    drv(); reset = 1'b0;
    drv();

    // Round robin: all four requesting, eight jobs, grants 0,1,2,3,0,1,2,3.
    for (int j = 0; j < 8; j++) begin
      jj = 16'(j);
      push_job(j % 4, {16'h3000 + jj, 16'h2000 + jj, 16'h1000 + jj, jj}, 1'b1, 1'b1);
    end
    res_ready = 1'b1;
    req = 4'b1111;
    wait_gnts(8);
    drv(); req = 4'b0;
    wait_res(8);

    // Single job with latency and hold-under-backpressure.
    drv(); res_ready = 1'b0;
    push_job(0, 64'h0004_0004_0004_0004, 1'b1, 1'b1);
    req = 4'b0001;
    wait_gnts(9);
    drv(); req = 4'b0;
    lat = 0;
    while (!res_valid && lat < 30) begin smp(); lat++; end
    check("latency", 80'(lat), 80'(5));
    for (int h = 0; h < 3; h++) begin
      check("hold", 80'({res_valid, res_id, res_freq}), 80'({1'b1, 2'd0, 64'h0004_0004_0004_0004}));
      smp();
    end
    drv(); res_ready = 1'b1;
    wait_res(9);

    // Backpressure: pointer is 1, id2 runs, then id1 waits behind the result.
    drv(); res_ready = 1'b0;
    push_job(2, 64'h1234_5678_9abc_def0, 1'b1, 1'b1);
    req = 4'b0100;
    wait_gnts(10);
    drv(); req = 4'b0;
    lat = 0;
    while (!res_valid && lat < 30) begin smp(); lat++; end
    check("bp_valid", 80'(res_valid), 80'(1'b1));
    drv(); req = 4'b0010;
    for (int h = 0; h < 10; h++) begin
      smp();
      check("bp_stall", 80'({gnt, core_new_t, res_valid}), 80'({4'b0, 1'b0, 1'b1}));
    end
    push_job(1, 64'hfedc_ba98_7654_3210, 1'b1, 1'b1);
    drv(); res_ready = 1'b1;
    wait_gnts(11);
    drv(); req = 4'b0;
    wait_res(11);

    // Timeout: pointer is 2, id3 runs on a core that never starts.
    drv(); core_stuck = 1'b1;
    push_job(3, 64'h0, 1'b0, 1'b0);
    req = 4'b1000;
    wait_gnts(12);
    drv(); req = 4'b0;
    lat = 0; saw_v = 1'b0;
    while (!timeout_err && lat < 40) begin
      smp(); lat++;
      if (res_valid) saw_v = 1'b1;
    end
    check("to_latency", 80'(lat), 80'(17));
    check("to_no_valid", 80'(saw_v), 80'(1'b0));
    smp();
    check("to_pulse", 80'({timeout_err, busy}), 80'(2'b00));
    drv(); core_stuck = 1'b0;
    push_job(0, 64'h0102_0304_0506_0708, 1'b1, 1'b1);
    req = 4'b1111;
    wait_gnts(13);
    drv(); req = 4'b0;
    wait_res(12);

    // Wrap: move pointer to 3 via id2, then req=1001 must pick id3.
    push_job(2, 64'h1111_2222_3333_4444, 1'b1, 1'b1);
    drv(); req = 4'b0100;
    wait_gnts(14);
    drv(); req = 4'b0;
    wait_res(13);
    push_job(3, 64'h5555_6666_7777_8888, 1'b1, 1'b1);
    drv(); req = 4'b1001;
    wait_gnts(15);
    drv(); req = 4'b0;
    wait_res(14);

    // Reset in the middle of WAIT abandons the job silently.
    drv(); core_lat = 8;
    push_job(0, 64'hdead_beef_dead_beef, 1'b1, 1'b0);
    req = 4'b0001;
    wait_gnts(16);
    drv(); req = 4'b0;
    smp(); smp();
    check("mid_wait", 80'({busy, core_done}), 80'(2'b10));
    drv(); reset = 1'b1;
    #1;
    check("rstm_ctl", 80'({gnt, core_new_t, res_valid, busy, timeout_err}), 80'(8'h0));
    check("rstm_pts", 80'({core_pt3, core_pt2, core_pt1, core_pt0}), 80'(40'h0));
    check("rstm_res", 80'({res_id, res_freq}), 80'(66'h0));
    drv(); drv(); reset = 1'b0; core_lat = 1;
    push_job(0, 64'h0a0a_0b0b_0c0c_0d0d, 1'b1, 1'b1);
    drv(); req = 4'b0001;
    wait_gnts(17);
    drv(); req = 4'b0;
    wait_res(15);

    repeat (5) smp();
    check("gnt_q_empty", 80'(exp_gnt_q.size()), 80'(0));
    check("frame_q_empty", 80'(exp_frame_q.size()), 80'(0));
    check("res_q_empty", 80'(exp_res_q.size()), 80'(0));
    check("timeouts", 80'(n_to_seen), 80'(1));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
